// File: rtl/dut_pkg.sv
// Shared definitions for the tiny-ALU command responder.
//   operation_t  : opcode encoding 0..10
//   ERR_*        : error codes returned on err
//   LAT_*        : capture-to-done latencies in clock cycles
//   addr_bad     : flags an address operand outside the register file
//   exec_cycles  : EXEC-state timer preload for the fixed-latency ops
package dut_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_AND = 4'd2,
    OP_XOR = 4'd3,
    OP_MUL = 4'd4,
    OP_DIV = 4'd5,
    OP_LDA = 4'd6,
    OP_STA = 4'd7,
    OP_MOV = 4'd8,
    OP_SWP = 4'd9,
    OP_WMR = 4'd10
  } operation_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DONE,
    ST_REST
  } state_t;

  localparam logic [7:0] ERR_OK      = 8'd0;
  localparam logic [7:0] ERR_DIV0    = 8'd1;
  localparam logic [7:0] ERR_ADDR    = 8'd2;
  localparam logic [7:0] ERR_ILLEGAL = 8'd3;

  localparam int NUM_REGS   = 16;
  localparam int ADDR_W     = 4;
  localparam int DIV_CYCLES = 32;
  localparam int LAT_BASIC  = 2;
  localparam int LAT_MUL    = 4;

  function automatic logic addr_bad(input logic [31:0] addr);
    return |addr[31:ADDR_W];
  endfunction

  // The divider finishes on its own done pulse; every other op uses the timer.
  function automatic logic [5:0] exec_cycles(input logic [7:0] op);
    return (op == 8'(OP_MUL)) ? 6'(LAT_MUL - 1) : 6'(LAT_BASIC - 1);
  endfunction

endpackage

// File: rtl/alu_cmd_responder_if.sv
// Command bus between the initiator (master) and the responder (slave).
//   start, sv, op_prefix, op, A, B : command from the initiator
//   done, gp, result, err          : response from the responder
interface alu_cmd_responder_if;
  logic        start;
  logic        sv;
  logic        op_prefix;
  logic [7:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        done;
  logic        gp;
  logic [63:0] result;
  logic [7:0]  err;

  modport master (output start, sv, op_prefix, op, A, B,
                  input  done, gp, result, err);
  modport slave  (input  start, sv, op_prefix, op, A, B,
                  output done, gp, result, err);
endinterface

// File: rtl/alu_div_iter.sv
// Restoring divider, one quotient bit per cycle over DIV_CYCLES cycles.
// Operands are converted to magnitudes on start; signs are re-applied in
// a final fix-up cycle (quotient truncates toward zero, remainder follows
// the dividend's sign).
//   clk, reset_n           : clock, async active-low reset
//   start, sv              : load operands (ignored while busy), signed mode
//   dividend, divisor      : operands, divisor must be nonzero
//   busy, done             : iterating / one-cycle result-valid pulse
//   quotient, remainder    : signed-corrected results, held until next done
module alu_div_iter
  import dut_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        sv,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] quo, rem, dvs;
  logic [4:0]  cnt;
  logic        neg_q, neg_r, fix;
  logic [32:0] trial;

  assign trial = {rem, quo[31]} - {1'b0, dvs};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      quo       <= '0;
      rem       <= '0;
      dvs       <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      fix       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      done <= 1'b0;
      fix  <= 1'b0;
      if (start && !busy) begin
        quo   <= (sv && dividend[31]) ? -dividend : dividend;
        dvs   <= (sv && divisor[31])  ? -divisor  : divisor;
        rem   <= '0;
        neg_q <= sv & (dividend[31] ^ divisor[31]);
        neg_r <= sv & dividend[31];
        cnt   <= 5'(DIV_CYCLES - 1);
        busy  <= 1'b1;
      end else if (busy) begin
        // Partial remainder always stays below the divisor, so it fits 32 bits.
        if (!trial[32]) begin
          rem <= trial[31:0];
          quo <= {quo[30:0], 1'b1};
        end else begin
          rem <= {rem[30:0], quo[31]};
          quo <= {quo[30:0], 1'b0};
        end
        if (cnt == '0) begin
          busy <= 1'b0;
          fix  <= 1'b1;
        end else begin
          cnt <= cnt - 5'd1;
        end
      end else if (fix) begin
        quotient  <= neg_q ? -quo : quo;
        remainder <= neg_r ? -rem : rem;
        done      <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_cmd_responder.sv
// Tiny-ALU command responder: captures one command per start handshake,
// executes ALU / divide / register-file ops and returns result, err, gp
// with a one-cycle done pulse.
//   clk, reset_n : clock, async active-low reset
//   bus          : command/response bus (slave side)
//
//   state | meaning
//   IDLE  | waiting for start; captures the command on start
//   EXEC  | timer or divider running
//   DONE  | done=1, result/err/gp just updated
//   REST  | one cycle with start ignored so a held start is not re-read stale
module alu_cmd_responder
  import dut_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  alu_cmd_responder_if.slave  bus
);

  state_t      state, state_nxt;
  logic [7:0]  op_q;
  logic        sv_q;
  logic [31:0] a_q, b_q, b_in;
  logic [5:0]  cnt;
  logic [31:0] regs [NUM_REGS];
  // result_q doubles as last_result: both update on every completion.
  logic [63:0] result_q, res_nxt;
  logic [7:0]  err_q, err_nxt;
  logic        gp_q;
  logic        capture, finish, div_wait;
  logic        div_go, div_busy, div_done;
  logic [31:0] div_q, div_r;
  logic [63:0] a_ext, b_ext;
  logic [31:0] ra, rb, wa_data, wb_data;
  logic        wr_a, wr_b, bad_a, bad_b;
  operation_t  op_e;

  assign b_in     = bus.op_prefix ? result_q[31:0] : bus.B;
  assign capture  = (state == ST_IDLE) && bus.start;
  assign div_go   = capture && (bus.op == 8'(OP_DIV)) && (b_in != '0) && !div_busy;
  assign div_wait = (op_q == 8'(OP_DIV)) && (b_q != '0);
  assign op_e     = operation_t'(op_q[3:0]);

  assign bus.done   = (state == ST_DONE);
  assign bus.result = result_q;
  assign bus.err    = err_q;
  assign bus.gp     = gp_q;

  alu_div_iter u_div (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (div_go),
    .sv        (bus.sv),
    .dividend  (bus.A),
    .divisor   (b_in),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  always_comb begin
    state_nxt = state;
    finish    = 1'b0;
    case (state)
      ST_IDLE: if (bus.start) state_nxt = ST_EXEC;
      ST_EXEC: begin
        finish = div_wait ? div_done : (cnt == '0);
        if (finish) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_REST;
      ST_REST: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    a_ext   = sv_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    b_ext   = sv_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    ra      = regs[a_q[ADDR_W-1:0]];
    rb      = regs[b_q[ADDR_W-1:0]];
    bad_a   = addr_bad(a_q);
    bad_b   = addr_bad(b_q);
    res_nxt = '0;
    err_nxt = ERR_OK;
    wr_a    = 1'b0;
    wr_b    = 1'b0;
    wa_data = '0;
    wb_data = '0;
    if (op_q > 8'd10) begin
      err_nxt = ERR_ILLEGAL;
    end else begin
      case (op_e)
        OP_NOP: res_nxt = '0;
        OP_ADD: res_nxt = a_ext + b_ext;
        OP_AND: res_nxt = {32'd0, a_q & b_q};
        OP_XOR: res_nxt = {32'd0, a_q ^ b_q};
        OP_MUL: res_nxt = a_ext * b_ext;
        OP_DIV: begin
          if (b_q == '0) begin
            err_nxt = ERR_DIV0;
            res_nxt = '1;
          end else begin
            res_nxt = {div_r, div_q};
          end
        end
        OP_LDA: begin
          if (bad_a) err_nxt = ERR_ADDR;
          else res_nxt = sv_q ? {{32{ra[31]}}, ra} : {32'd0, ra};
        end
        OP_STA: begin
          if (bad_a) err_nxt = ERR_ADDR;
          else begin
            wr_a    = 1'b1;
            wa_data = b_q;
            res_nxt = {32'd0, b_q};
          end
        end
        OP_MOV: begin
          if (bad_a || bad_b) err_nxt = ERR_ADDR;
          else begin
            wr_b    = 1'b1;
            wb_data = ra;
            res_nxt = {32'd0, ra};
          end
        end
        // With A==B both writes carry the same old value, so the swap is a no-op.
        OP_SWP: begin
          if (bad_a || bad_b) err_nxt = ERR_ADDR;
          else begin
            wr_a    = 1'b1;
            wa_data = rb;
            wr_b    = 1'b1;
            wb_data = ra;
            res_nxt = {rb, ra};
          end
        end
        OP_WMR: begin
          if (bad_a) err_nxt = ERR_ADDR;
          else begin
            wr_a    = 1'b1;
            wa_data = result_q[31:0];
            res_nxt = {32'd0, result_q[31:0]};
          end
        end
        default: err_nxt = ERR_ILLEGAL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      op_q     <= '0;
      sv_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      cnt      <= '0;
      result_q <= '0;
      err_q    <= ERR_OK;
      gp_q     <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        op_q <= bus.op;
        sv_q <= bus.sv;
        a_q  <= bus.A;
        b_q  <= b_in;
        cnt  <= exec_cycles(bus.op);
      end else if (state == ST_EXEC && cnt != '0) begin
        cnt <= cnt - 6'd1;
      end
      if (finish) begin
        result_q <= res_nxt;
        err_q    <= err_nxt;
        gp_q     <= (res_nxt != '0) && (!sv_q || !res_nxt[63]);
        if (wr_a) regs[a_q[ADDR_W-1:0]] <= wa_data;
        if (wr_b) regs[b_q[ADDR_W-1:0]] <= wb_data;
      end
    end
  end

endmodule
